// File: rtl/trap_ctrl.sv
// Trap entry/exit sequencer: walks MSTATUS, MEPC and MTVEC through a single CSR
// port for ecall and mret, then pulses a one-cycle fetch redirect.
module trap_ctrl #(
   parameter int CSR_DIG = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ecall_req,
   input  logic               mret_req,
   input  logic [31:0]        pc_in,
   output logic               req_ready,
   output logic [CSR_DIG-1:0] csr_read_addr,
   input  logic [31:0]        csr_rdata,
   output logic               csr_write,
   output logic [CSR_DIG-1:0] csr_write_addr,
   output logic [31:0]        csr_data,
   output logic               redirect_valid,
   output logic [31:0]        redirect_pc
);

   localparam logic [CSR_DIG-1:0] CSR_MSTATUS = CSR_DIG'(12'h300);
   localparam logic [CSR_DIG-1:0] CSR_MTVEC   = CSR_DIG'(12'h305);
   localparam logic [CSR_DIG-1:0] CSR_MEPC    = CSR_DIG'(12'h341);

   typedef enum logic [3:0] {
      IDLE, E_RST, E_WEPC, E_WST, E_RTVEC, M_REPC, M_RST, M_WST, DONE
   } state_t;

   state_t              state_q;
   logic [31:0]         st_q;
   logic [31:0]         pc_q;
   logic [31:0]         target_q;

   logic                ready_q;
   logic [CSR_DIG-1:0]  rd_addr_q;
   logic                wr_q;
   logic [CSR_DIG-1:0]  wr_addr_q;
   logic [31:0]         wr_data_q;
   logic                redir_q;
   logic [31:0]         redir_pc_q;

   logic [31:0]         target_d;
   logic [31:0]         entry_st_d;
   logic [31:0]         return_st_d;

   assign target_d = {csr_rdata[31:2], 2'b00};

   // Entry stacks MIE into MPIE and disables interrupts; return does the reverse.
   always_comb begin
      entry_st_d        = st_q;
      entry_st_d[7]     = st_q[3];
      entry_st_d[3]     = 1'b0;
      entry_st_d[12:11] = 2'b11;
      return_st_d        = csr_rdata;
      return_st_d[3]     = csr_rdata[7];
      return_st_d[7]     = 1'b1;
      return_st_d[12:11] = 2'b11;
   end

   // Outputs are registered against the state being entered, so each output
   // bundle is a pure function of state_q.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         st_q       <= '0;
         pc_q       <= '0;
         target_q   <= '0;
         ready_q    <= 1'b1;
         rd_addr_q  <= '0;
         wr_q       <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         redir_q    <= 1'b0;
         redir_pc_q <= '0;
      end else begin
         ready_q    <= 1'b0;
         rd_addr_q  <= '0;
         wr_q       <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         redir_q    <= 1'b0;
         redir_pc_q <= '0;
         case (state_q)
            IDLE: begin
               if (ecall_req) begin
                  pc_q      <= pc_in;
                  state_q   <= E_RST;
                  rd_addr_q <= CSR_MSTATUS;
               end else if (mret_req) begin
                  state_q   <= M_REPC;
                  rd_addr_q <= CSR_MEPC;
               end else begin
                  ready_q   <= 1'b1;
               end
            end
            E_RST: begin
               st_q      <= csr_rdata;
               state_q   <= E_WEPC;
               wr_q      <= 1'b1;
               wr_addr_q <= CSR_MEPC;
               wr_data_q <= pc_q;
            end
            E_WEPC: begin
               state_q   <= E_WST;
               wr_q      <= 1'b1;
               wr_addr_q <= CSR_MSTATUS;
               wr_data_q <= entry_st_d;
            end
            E_WST: begin
               state_q   <= E_RTVEC;
               rd_addr_q <= CSR_MTVEC;
            end
            E_RTVEC: begin
               target_q   <= target_d;
               state_q    <= DONE;
               redir_q    <= 1'b1;
               redir_pc_q <= target_d;
            end
            M_REPC: begin
               target_q  <= target_d;
               state_q   <= M_RST;
               rd_addr_q <= CSR_MSTATUS;
            end
            M_RST: begin
               // st_q is still loading this cycle, so the write data uses csr_rdata directly.
               st_q      <= csr_rdata;
               state_q   <= M_WST;
               wr_q      <= 1'b1;
               wr_addr_q <= CSR_MSTATUS;
               wr_data_q <= return_st_d;
            end
            M_WST: begin
               state_q    <= DONE;
               redir_q    <= 1'b1;
               redir_pc_q <= target_q;
            end
            DONE: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Holding rst low suppresses a write or redirect already showing in the current state.
   assign req_ready      = ready_q;
   assign csr_read_addr  = rst ? rd_addr_q  : '0;
   assign csr_write      = rst ? wr_q       : 1'b0;
   assign csr_write_addr = rst ? wr_addr_q  : '0;
   assign csr_data       = rst ? wr_data_q  : '0;
   assign redirect_valid = rst ? redir_q    : 1'b0;
   assign redirect_pc    = rst ? redir_pc_q : '0;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: CSR_DIG, 12, CSR address width.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst  in  1  reset, synchronous, active-low; asserted when 0.
REQ-004 Port: ecall_req  in  1  trap-entry request; accepted only while req_ready=1.
REQ-005 Port: mret_req  in  1  trap-return request; accepted only while req_ready=1.
REQ-006 Port: pc_in  in  32  PC of the ecall instruction; sampled on accept.
REQ-007 Port: req_ready  out  1  high only in IDLE.
REQ-008 Port: csr_read_addr  out  CSR_DIG  CSR read address; 0 when not reading.
REQ-009 Port: csr_rdata  in  32  combinational read data for csr_read_addr, same cycle.
REQ-010 Port: csr_write  out  1  CSR write strobe.
REQ-011 Port: csr_write_addr  out  CSR_DIG  CSR write address; 0 when csr_write=0.
REQ-012 Port: csr_data  out  32  CSR write data; 0 when csr_write=0.
REQ-013 Port: redirect_valid  out  1  one-cycle pulse: fetch shall jump to redirect_pc.
REQ-014 Port: redirect_pc  out  32  target PC; valid only while redirect_valid=1.

Function
REQ-015 The block SHALL use CSR addresses MSTATUS=0x300, MTVEC=0x305, MEPC=0x341.
REQ-016 The block SHALL be a Moore FSM with states IDLE, E_RST, E_WEPC, E_WST, E_RTVEC, M_REPC, M_RST, M_WST, DONE.
REQ-017 In IDLE, ecall_req=1 SHALL latch pc_in and move to E_RST; otherwise mret_req=1 SHALL move to M_REPC.
REQ-018 Simultaneous ecall_req and mret_req SHALL take the ecall path; the mret is dropped.
REQ-019 Requests while req_ready=0 SHALL be ignored, with no queuing.
REQ-020 E_RST: csr_read_addr=MSTATUS; latch csr_rdata into st_q; go to E_WEPC.
REQ-021 E_WEPC: csr_write=1, addr=MEPC, data=latched pc; go to E_WST.
REQ-022 E_WST: csr_write=1, addr=MSTATUS, data=st_q with bit7(MPIE)=st_q[3], bit3(MIE)=0, bits[12:11](MPP)=2'b11, all other bits unchanged; go to E_RTVEC.
REQ-023 E_RTVEC: csr_read_addr=MTVEC; latch {csr_rdata[31:2],2'b00} as target; go to DONE.
REQ-024 M_REPC: csr_read_addr=MEPC; latch {csr_rdata[31:2],2'b00} as target; go to M_RST.
REQ-025 M_RST: csr_read_addr=MSTATUS; latch into st_q; go to M_WST.
REQ-026 M_WST: csr_write=1, addr=MSTATUS, data=st_q with bit3=st_q[7], bit7=1, bits[12:11]=2'b11, others unchanged; go to DONE.
REQ-027 DONE: redirect_valid=1, redirect_pc=target; go to IDLE, with req_ready high the following cycle.
REQ-028 Latency: an ecall accepted at edge T SHALL pulse redirect_valid during the cycle after edge T+4; an mret SHALL do so after edge T+3.
REQ-029 At most one CSR write SHALL occur per cycle, and csr_write SHALL never be asserted in IDLE or DONE.
REQ-030 redirect_pc SHALL read 0 whenever redirect_valid=0.

Reset
REQ-031 While rst=0 at a rising edge, state SHALL become IDLE and st_q, latched pc and target SHALL clear to 0.
REQ-032 All outputs SHALL be 0 during reset except req_ready, which SHALL be 1 once in IDLE.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence with no further CSR write and no redirect pulse; CSR writes completed before reset are not undone.

Verification
REQ-034 ecall with pc_in=0x80000100, MSTATUS=0x00000008, MTVEC=0x80000403 -> MEPC written 0x80000100, then MSTATUS written 0x00001880, then redirect_pc=0x80000400 pulsed exactly 5 cycles after accept.
REQ-035 mret with MEPC=0x80000104, MSTATUS=0x00001880 -> MSTATUS written 0x00001888, redirect_pc=0x80000104 pulsed 4 cycles after accept, and no MEPC write.
REQ-036 ecall_req=1 and mret_req=1 in the same IDLE cycle -> ecall sequence only, with MEPC written.
REQ-037 mret_req pulsed during E_WEPC -> ignored, exactly one redirect pulse, and req_ready=1 the cycle after DONE.
REQ-038 rst=0 during E_WST -> no MSTATUS write, no redirect pulse, state IDLE, and a fresh ecall then completes normally.
REQ-039 Back-to-back ecall then mret (mret raised the first cycle req_ready=1) -> two redirect pulses separated by 5 cycles, and the final MSTATUS has MIE restored.
